// File: rtl/systolic_array_pkg.sv
// -----------------------------------------------------------------------------
// systolic_array_pkg
// Shared types for the systolic array datapath and its feeder.
//   word_t         : one activation/weight element
//   feeder_state_t : control states of systolic_feeder
// -----------------------------------------------------------------------------
package systolic_array_pkg;

   typedef logic [15:0] word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } feeder_state_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// -----------------------------------------------------------------------------
// systolic_feeder_if
// Bundles the tile-load bus, the go/busy/done control and the array-facing
// x_in/w_in/start/stall signals of systolic_feeder.
//   master : the environment (SRAM readers, controller, array stall source)
//   slave  : the feeder itself
// Signals:
//   ld_valid/ld_ready/ld_sel/ld_idx/ld_data : one tile row per accepted beat
//   go/busy/done                            : stream control and status
//   x_in/w_in/start                         : skewed vectors toward the array
//   stall                                   : back-pressure from the array
// -----------------------------------------------------------------------------
interface systolic_feeder_if #(
   parameter int N = 4
) ();
   import systolic_array_pkg::*;

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   logic               ld_valid;
   logic               ld_ready;
   logic               ld_sel;
   logic [IDX_W-1:0]   ld_idx;
   word_t [N-1:0]      ld_data;
   logic               go;
   logic               busy;
   logic               done;
   word_t [N-1:0]      x_in;
   word_t [N-1:0]      w_in;
   logic               start;
   logic               stall;

   modport master (
      output ld_valid, ld_sel, ld_idx, ld_data, go, stall,
      input  ld_ready, busy, done, x_in, w_in, start
   );

   modport slave (
      input  ld_valid, ld_sel, ld_idx, ld_data, go, stall,
      output ld_ready, busy, done, x_in, w_in, start
   );

endinterface

// File: rtl/systolic_feeder_tile_buf.sv
// -----------------------------------------------------------------------------
// feeder_tile_buf
// N x N word_t tile store with one row write port and N diagonal read lanes
// addressed by the stream step t.
//   ROW_READ=1 : lane i returns mem[i][t-i]   (activation tile, row per lane)
//   ROW_READ=0 : lane j returns mem[t-j][j]   (weight tile, column per lane)
// A lane outside its diagonal window (t-lane < 0 or >= N) returns zero.
// Ports:
//   clk, n_rst     : clock, synchronous active-high reset (clears storage)
//   we/widx/wdata  : row write; element k of wdata lands in column k
//   t              : stream step
//   rd             : N read lanes
// -----------------------------------------------------------------------------
module feeder_tile_buf
   import systolic_array_pkg::*;
#(
   parameter int N        = 4,
   parameter bit ROW_READ = 1'b1,
   localparam int IDX_W   = (N > 1) ? $clog2(N) : 1,
   localparam int TW      = $clog2(2 * N)
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              we,
   input  logic [IDX_W-1:0]  widx,
   input  word_t [N-1:0]     wdata,
   input  logic [TW-1:0]     t,
   output word_t [N-1:0]     rd
);

   word_t [N-1:0] mem [N];

   // Row storage; the caller guarantees widx < N whenever we is high.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         for (int r = 0; r < N; r++) begin
            mem[r] <= '0;
         end
      end else if (we) begin
         mem[widx] <= wdata;
      end
   end

   // Each lane computes its diagonal offset t-lane in one extra signed bit
   // so that lanes not yet reached (negative offset) are distinguishable.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic signed [TW:0]  d;
      logic                in_range;
      logic [IDX_W-1:0]    col;

      assign d        = $signed({1'b0, t}) - $signed((TW+1)'(i));
      assign in_range = !d[TW] && (d < $signed((TW+1)'(N)));
      assign col      = d[IDX_W-1:0];

      if (ROW_READ) begin : g_row
         assign rd[i] = in_range ? mem[i][col] : '0;
      end else begin : g_col
         assign rd[i] = in_range ? mem[col][i] : '0;
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
// Collects one N x N activation tile X and one N x N weight tile W, then on
// go streams them into the systolic array as diagonally skewed vectors over
// 2N-1 steps, honouring the array stall and pulsing done at the end.
// Ports:
//   clk   : clock
//   n_rst : synchronous reset, asserted HIGH despite the name
//   bus   : systolic_feeder_if slave modport (load bus, go/busy/done,
//           x_in/w_in/start toward the array, stall from the array)
// The N parameter must match the N of the connected interface.
// -----------------------------------------------------------------------------
module systolic_feeder
   import systolic_array_pkg::*;
#(
   parameter int N = 4
) (
   input  logic              clk,
   input  logic              n_rst,
   systolic_feeder_if.slave  bus
);

   localparam int            TW     = $clog2(2 * N);
   localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);

   feeder_state_t  state;
   logic [TW-1:0]  t;
   logic [N-1:0]   x_mask;
   logic [N-1:0]   w_mask;

   logic           idx_ok;
   logic           ld_fire;
   logic           x_we;
   logic           w_we;
   word_t [N-1:0]  x_rd;
   word_t [N-1:0]  w_rd;

   // Beats are only taken in IDLE; an out-of-range row index is swallowed
   // without touching storage or the masks.
   assign idx_ok  = (int'(bus.ld_idx) < N);
   assign ld_fire = bus.ld_valid && (state == IDLE);
   assign x_we    = ld_fire && !bus.ld_sel && idx_ok;
   assign w_we    = ld_fire &&  bus.ld_sel && idx_ok;

   feeder_tile_buf #(
      .N        (N),
      .ROW_READ (1'b1)
   ) u_x_buf (
      .clk   (clk),
      .n_rst (n_rst),
      .we    (x_we),
      .widx  (bus.ld_idx),
      .wdata (bus.ld_data),
      .t     (t),
      .rd    (x_rd)
   );

   feeder_tile_buf #(
      .N        (N),
      .ROW_READ (1'b0)
   ) u_w_buf (
      .clk   (clk),
      .n_rst (n_rst),
      .we    (w_we),
      .widx  (bus.ld_idx),
      .wdata (bus.ld_data),
      .t     (t),
      .rd    (w_rd)
   );

   // Control FSM. In IDLE, go is tested against the mask registers as they
   // were before this cycle's load beat, so a beat that completes a tile
   // cannot enable a go in the same cycle. Masks are dropped on the way to
   // DONE so every stream needs freshly loaded tiles.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         state  <= IDLE;
         t      <= '0;
         x_mask <= '0;
         w_mask <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (x_we) begin
                  x_mask[bus.ld_idx] <= 1'b1;
               end
               if (w_we) begin
                  w_mask[bus.ld_idx] <= 1'b1;
               end
               if (bus.go && (&x_mask) && (&w_mask)) begin
                  state <= STREAM;
                  t     <= '0;
               end
            end
            STREAM: begin
               if (!bus.stall) begin
                  if (t == T_LAST) begin
                     state  <= DONE;
                     t      <= '0;
                     x_mask <= '0;
                     w_mask <= '0;
                  end else begin
                     t <= t + 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Outputs decode only the state and step registers, so a stall simply
   // re-presents the same vector on the next cycle.
   assign bus.ld_ready = (state == IDLE);
   assign bus.busy     = (state != IDLE);
   assign bus.done     = (state == DONE);
   assign bus.start    = (state == STREAM) && (t == '0);
   assign bus.x_in     = (state == STREAM) ? x_rd : '0;
   assign bus.w_in     = (state == STREAM) ? w_rd : '0;

endmodule
